clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Programmable clock-divider controller. It generates a divided clock `out_clk` and a period-start strobe `out_tick` from `clk`. Divide-ratio updates arrive over a valid/ready handshake and take effect only at period boundaries, and enable/disable never produces a truncated pulse. It sequences the divider datapath for downstream blocks that need glitch-free, software-retunable slow clocks or enables.

## Interface
- `CNT_W`, default 8: width of the divide ratio and of the internal period counter.
- `DIV_RESET`, default 2: ratio loaded at reset. Must be ≥2, and even when `DIV_ODD_EN` is undefined.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rstN`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run request (level).
- `cfg_valid`  in  1  ratio update request.
- `cfg_div`  in  CNT_W  requested divide ratio N.
- `cfg_ready`  out  1  controller can accept an update.
- `cfg_err`  out  1  one-cycle pulse: last accepted update was rejected.
- `out_clk`  out  1  divided clock, registered.
- `out_tick`  out  1  one-cycle pulse in the first cycle of each period.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Registers:
  - `div_cur`, the active ratio.
  - `div_pend` plus `pend_v`, a one-deep pending update.
  - `cnt`, range 0..div_cur-1.
  - `state`: IDLE, RUN or DRAIN.
- Waveform: in RUN/DRAIN, `out_clk`=1 in exactly those cycles where `cnt` < (div_cur>>1), else 0.
  - Even N gives 50% duty.
  - Odd N is high for floor(N/2) cycles and low for ceil(N/2) cycles.
- `out_tick`=1 exactly in cycles where `cnt`==0 in RUN/DRAIN.
- A wrap is a cycle with `cnt`==div_cur-1 in RUN/DRAIN. The next `cnt` is 0.
- State transitions:
  - IDLE: `cnt`=0, `out_clk`=0. If `en`=1 → RUN; the next cycle has `cnt`=0, `out_clk`=1, `out_tick`=1.
  - RUN: if `en`=0 → DRAIN; counting continues unchanged.
  - DRAIN: if `en`=1 → RUN with no disturbance to `cnt`. At a wrap with `en`=0 → IDLE.
  - RUN with `en`=0 exactly at a wrap → IDLE directly.
- Validity: an update is valid iff `cfg_div` ≥ 2 (with `DIV_ODD_EN`) or `cfg_div` ≥ 2 and even (without it).
- `cfg_ready`=1 when `pend_v`=0, or when in IDLE.
- Accepting an update (`cfg_valid` && `cfg_ready`):
  - Invalid: `cfg_err`=1 in the next cycle; no register changes.
  - Valid, in IDLE: `div_cur` ← `cfg_div` next cycle; `pend_v` stays 0.
  - Valid, in RUN/DRAIN: `div_pend` ← `cfg_div`, `pend_v` ← 1.
- At a wrap with `pend_v`=1: `div_cur` ← `div_pend`, `pend_v` ← 0. The new period, starting at `cnt`=0, uses the new ratio.
- Update accepted in the same cycle as a wrap: it lands in pending and applies at the following wrap. There is no same-cycle bypass.
- Wrap that enters IDLE with `pend_v`=1: the pending value is still committed to `div_cur`.

## Timing
- Reset values (asynchronous on `rstN`=0):
  - `state`=IDLE, `cnt`=0, `div_cur`=DIV_RESET, `pend_v`=0.
  - `out_clk`=0, `out_tick`=0, `cfg_err`=0, `cfg_ready`=1, `busy`=0.
- Reset asserted mid-period forces `out_clk` low immediately and discards any pending update.
- `en` rise in IDLE → first `out_clk`/`out_tick` high one cycle later.
- `cfg_ready` falls in the cycle after an accept in RUN/DRAIN. It rises in the cycle after the committing wrap.
- Ratio-change latency: up to div_cur + 1 cycles from accept to first period at the new ratio.
- Every `out_clk` high phase is full length; no runt pulses on enable, disable or ratio change.
- All outputs are registered; none depend combinationally on the inputs.

## Configuration
- `DIV_ODD_EN`:
  - Defined: odd ratios ≥3 are accepted, with the asymmetric duty above.
  - Undefined: odd ratios are rejected with `cfg_err`, and duty is always exactly 50%.

## Test plan
- Reset, then `en`=1 with DIV_RESET=2 → `out_clk` toggles 1,0,1,0; `out_tick` every 2 cycles; `busy`=1.
- In RUN at N=2, accept `cfg_div`=6 → `cfg_ready` low until the wrap; then period 6 (3 high, 3 low), `out_tick` every 6 cycles.
- Send `cfg_div`=1 → `cfg_err` pulses one cycle; period unchanged. Send 5 → `cfg_err` without `DIV_ODD_EN`; with it, 2 high / 3 low.
- At N=8, deassert `en` when `cnt`=2 → the period completes through `cnt`=7, then IDLE with `out_clk`=0; reassert `en` during DRAIN → no gap in the period sequence.
- Accept `cfg_div`=4 exactly in a wrap cycle → the current period stays at the old N; 4 applies at the next wrap.
- Drop `rstN` mid-high-phase with `pend_v`=1 → `out_clk`=0 immediately, `div_cur`=DIV_RESET, `cfg_ready`=1.

Source files
------------

// File: rtl/clk_div_ctrl_if.sv
// Ratio-update handshake between a configuring master and clk_div_ctrl.
// The master offers cfg_div with cfg_valid; the controller answers with cfg_ready and cfg_err.
interface clk_div_ctrl_if #(
    parameter int CNT_W = 8
);
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             cfg_err;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready,
        input  cfg_err
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready,
        output cfg_err
    );
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock divider. Ratio updates are committed only at period boundaries, and enable/disable never truncates a pulse.
// Define DIV_ODD_EN to accept odd ratios (asymmetric duty); without it, only even ratios >= 2 are accepted.
module clk_div_ctrl #(
    parameter int CNT_W     = 8,
    parameter int DIV_RESET = 2
) (
    input  logic           clk,
    input  logic           rstN,
    input  logic           en,
    clk_div_ctrl_if.slave  cfg,
    output logic           out_clk,
    output logic           out_tick,
    output logic           busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] div_pend_q, div_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             out_clk_q, out_clk_d;
    logic             out_tick_q, out_tick_d;
    logic             busy_q, busy_d;

    logic active;
    logic wrap;
    logic accept;
    logic div_ok;

    assign active = (state_q != IDLE);
    assign wrap   = active && (cnt_q == div_cur_q - CNT_W'(1));
    assign accept = cfg.cfg_valid && cfg_ready_q;

`ifdef DIV_ODD_EN
    assign div_ok = (cfg.cfg_div >= CNT_W'(2));
`else
    assign div_ok = (cfg.cfg_div >= CNT_W'(2)) && !cfg.cfg_div[0];
`endif

    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_cur_d  = div_cur_q;
        div_pend_d = div_pend_q;
        pend_v_d   = pend_v_q;
        cfg_err_d  = 1'b0;

        unique case (state_q)
            IDLE:    if (en) state_d = RUN;
            RUN:     if (!en) state_d = wrap ? IDLE : DRAIN;
            DRAIN:   if (en) state_d = RUN;
                     else if (wrap) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (active)
            cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
        else
            cnt_d = '0;

        // A pending ratio is committed at the wrap even when that wrap drops into IDLE.
        if (wrap && pend_v_q) begin
            div_cur_d = div_pend_q;
            pend_v_d  = 1'b0;
        end

        if (accept) begin
            if (!div_ok) begin
                cfg_err_d = 1'b1;
            end else if (state_q == IDLE) begin
                div_cur_d = cfg.cfg_div;
                pend_v_d  = 1'b0;
            end else begin
                div_pend_d = cfg.cfg_div;
                pend_v_d   = 1'b1;
            end
        end

        // Outputs are derived from next-state values so they can be registered without a cycle of lag.
        busy_d      = (state_d != IDLE);
        out_clk_d   = busy_d && (cnt_d < (div_cur_d >> 1));
        out_tick_d  = busy_d && (cnt_d == '0);
        cfg_ready_d = !pend_v_d || (state_d == IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            div_cur_q   <= CNT_W'(DIV_RESET);
            div_pend_q  <= '0;
            pend_v_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            cfg_ready_q <= 1'b1;
            out_clk_q   <= 1'b0;
            out_tick_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_cur_q   <= div_cur_d;
            div_pend_q  <= div_pend_d;
            pend_v_q    <= pend_v_d;
            cfg_err_q   <= cfg_err_d;
            cfg_ready_q <= cfg_ready_d;
            out_clk_q   <= out_clk_d;
            out_tick_q  <= out_tick_d;
            busy_q      <= busy_d;
        end
    end

    assign cfg.cfg_ready = cfg_ready_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign out_clk       = out_clk_q;
    assign out_tick      = out_tick_q;
    assign busy          = busy_q;
endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl: inputs change and outputs are sampled on the falling edge.
// Honours DIV_ODD_EN when the bench and RTL are built with it.
module tb_clk_div_ctrl;
    localparam int CNT_W = 8;
`ifdef DIV_ODD_EN
    localparam int N_MID = 5;
`else
    localparam int N_MID = 6;
`endif

    logic clk = 1'b0;
    logic rstN;
    logic en;
    logic out_clk;
    logic out_tick;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    clk_div_ctrl_if #(.CNT_W(CNT_W)) cfg_if ();

    clk_div_ctrl #(.CNT_W(CNT_W), .DIV_RESET(2)) dut (
        .clk      (clk),
        .rstN     (rstN),
        .en       (en),
        .cfg      (cfg_if),
        .out_clk  (out_clk),
        .out_tick (out_tick),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Checks one full period of ratio n starting at the currently observed cnt=0 cycle; leaves cnt at n-1.
    task automatic check_period(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            if (k > 0) step();
            check({tag, "_clk"}, 32'(out_clk), 32'(k < n / 2));
            check({tag, "_tick"}, 32'(out_tick), 32'(k == 0));
        end
    endtask

    task automatic wait_tick(input string tag);
        int cycles = 0;
        do begin
            step();
            cycles++;
        end while (!out_tick && cycles < 64);
        if (!out_tick) check({tag, "_timeout"}, 32'(out_tick), 32'd1);
    endtask

    initial begin
        rstN = 1'b0;
        en = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div = '0;
        step();
        step();
        check("rst_out_clk", 32'(out_clk), 32'd0);
        check("rst_tick", 32'(out_tick), 32'd0);
        check("rst_err", 32'(cfg_if.cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rstN = 1'b1;
        step();
        check("idle_clk", 32'(out_clk), 32'd0);

        // N=2 after enable: 1,0,1,0 with a tick every other cycle
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("n2_clk", 32'(out_clk), 32'((i % 2) == 0));
            check("n2_tick", 32'(out_tick), 32'((i % 2) == 0));
            check("n2_busy", 32'(busy), 32'd1);
        end

        // Accept 6 in a wrap cycle: old period of 2 runs once more, then 6 applies
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd6;
        step();
        cfg_if.cfg_valid = 1'b0;
        check("acc6_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check("acc6_clk", 32'(out_clk), 32'd1);
        step();
        check("acc6_ready_hold", 32'(cfg_if.cfg_ready), 32'd0);
        check("acc6_clk_low", 32'(out_clk), 32'd0);
        step();
        check("acc6_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
        check_period("n6", 6);

        // Invalid ratio 1, then 5 (odd)
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd1;
        step();
        cfg_if.cfg_valid = 1'b0;
        check("div1_err", 32'(cfg_if.cfg_err), 32'd1);
        check("div1_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check("div1_tick", 32'(out_tick), 32'd1);
        step();
        check("div1_err_end", 32'(cfg_if.cfg_err), 32'd0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd5;
        step();
        cfg_if.cfg_valid = 1'b0;
`ifdef DIV_ODD_EN
        check("div5_err", 32'(cfg_if.cfg_err), 32'd0);
        check("div5_ready", 32'(cfg_if.cfg_ready), 32'd0);
`else
        check("div5_err", 32'(cfg_if.cfg_err), 32'd1);
        check("div5_ready", 32'(cfg_if.cfg_ready), 32'd1);
`endif
        wait_tick("mid");
        check_period("nmid", N_MID);

        // Accept 4 exactly at a wrap: current period stays at the old ratio
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd4;
        step();
        cfg_if.cfg_valid = 1'b0;
        check("wrap4_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check_period("old_n", N_MID);
        step();
        check("wrap4_ready_back", 32'(cfg_if.cfg_ready), 32'd1);
        check_period("n4", 4);

        // Move to N=8
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd8;
        step();
        cfg_if.cfg_valid = 1'b0;
        wait_tick("to8");
        check("n8_start_clk", 32'(out_clk), 32'd1);
        step();
        step();
        // Drop en at cnt=2: period completes through cnt=7, then IDLE
        en = 1'b0;
        for (int c = 3; c < 8; c++) begin
            step();
            check("drain_clk", 32'(out_clk), 32'(c < 4));
            check("drain_busy", 32'(busy), 32'd1);
        end
        step();
        check("drain_idle_clk", 32'(out_clk), 32'd0);
        check("drain_idle_busy", 32'(busy), 32'd0);
        check("drain_idle_tick", 32'(out_tick), 32'd0);
        step();
        check("idle_stay_clk", 32'(out_clk), 32'd0);

        // Restart, then bounce en during DRAIN: period sequence uninterrupted
        en = 1'b1;
        step();
        check("restart_tick", 32'(out_tick), 32'd1);
        check("restart_clk", 32'(out_clk), 32'd1);
        step();
        step();
        en = 1'b0;
        step();
        step();
        en = 1'b1;
        step();
        check("rerun_clk", 32'(out_clk), 32'd0);
        check("rerun_busy", 32'(busy), 32'd1);
        check("rerun_tick", 32'(out_tick), 32'd0);
        step();
        step();
        step();
        check("rerun_wrap_tick", 32'(out_tick), 32'd1);
        check("rerun_wrap_clk", 32'(out_clk), 32'd1);

        // Reset mid-high-phase with an update pending
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_div = 8'd4;
        step();
        cfg_if.cfg_valid = 1'b0;
        check("pend_ready", 32'(cfg_if.cfg_ready), 32'd0);
        check("pend_clk", 32'(out_clk), 32'd1);
        #2 rstN = 1'b0;
        #1;
        check("midrst_clk", 32'(out_clk), 32'd0);
        check("midrst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        step();
        rstN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_clk", 32'(out_clk), 32'((i % 2) == 0));
            check("post_rst_tick", 32'(out_tick), 32'((i % 2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
